fb_scan_arbiter: RTL and testbench

- Shares one single-port, synchronous-read pixel RAM between VGA scan-out reads and host pixel writes.
- Framebuffer is 160x120 at 3 bits/pixel; each stored pixel is displayed as a 4x4 block on the 640x480 screen.
- Sits between the hsync/vsync timing generator (counters, inDisplayArea, syncs in) and the VGA pins (pixel, hsync_out, vsync_out).
- Also runs a clear-screen fill sequence. Scan-out always has priority; writes use the free RAM slots.

---
 rtl/fb_scan_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fb_scan_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: shares one synchronous-read pixel RAM between VGA scan-out
// (priority, one read per 4-pixel group) and host writes / clear-screen fill
// (remaining slots). All VGA outputs carry a fixed 3-cycle latency.
module fb_scan_arbiter #(
   parameter int FB_W   = 160,
   parameter int FB_H   = 120,
   parameter int ADDR_W = 15
) (
   input  logic              clk_25,
   input  logic              reset,
   input  logic [9:0]        counter_x,
   input  logic [9:0]        counter_y,
   input  logic              in_display_area,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_x,
   input  logic [6:0]        wr_y,
   input  logic [2:0]        wr_color,
   output logic              wr_drop,
   input  logic              clear_start,
   input  logic [2:0]        clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [2:0]        ram_wdata,
   input  logic [2:0]        ram_rdata,
   output logic [2:0]        pixel,
   output logic              hsync_out,
   output logic              vsync_out
);

   typedef enum logic {IDLE, CLEAR} state_e;

   localparam logic [8:0]        FB_W_L = 9'(FB_W);
   localparam logic [7:0]        FB_H_L = 8'(FB_H);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(FB_W * FB_H - 1);

   // y*160 + x built from shifts so no multiplier is needed
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
      logic [ADDR_W-1:0] yy;
      yy = ADDR_W'(y);
      return (yy << 7) + (yy << 5) + ADDR_W'(x);
   endfunction

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [2:0]        clr_col_q, clr_col_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [2:0]        ram_wdata_q, ram_wdata_d;
   logic              clear_done_q, clear_done_d;
   logic              wr_drop_q, wr_drop_d;
   logic              rvld_q;
   logic [2:0]        hold_q;
   logic [2:0]        de_q, hs_q, vs_q;

   logic rd_slot, in_range, xfer;
   logic unused_ok;

   assign unused_ok = ^{counter_y[9], counter_y[1:0]};

   // slot decode and host handshake
   always_comb begin
      rd_slot  = in_display_area && (counter_x[1:0] == 2'b00);
      in_range = ({1'b0, wr_x} < FB_W_L) && ({1'b0, wr_y} < FB_H_L);
      wr_ready = !rd_slot && (state_q == IDLE) && !reset;
      xfer     = wr_valid && wr_ready;
   end

   // next-state: port arbitration (scan > fill > host) and fill FSM
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      clr_col_d    = clr_col_q;
      ram_en_d     = 1'b0;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      clear_done_d = 1'b0;
      wr_drop_d    = xfer && !in_range;

      if (rd_slot) begin
         ram_en_d   = 1'b1;
         ram_addr_d = pix_addr(counter_x[9:2], counter_y[8:2]);
      end else if (state_q == CLEAR) begin
         ram_en_d    = 1'b1;
         ram_we_d    = 1'b1;
         ram_addr_d  = clr_cnt_q;
         ram_wdata_d = clr_col_q;
         clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
         if (clr_cnt_q == LAST) begin
            state_d      = IDLE;
            clear_done_d = 1'b1;
         end
      end else if (xfer && in_range) begin
         ram_en_d    = 1'b1;
         ram_we_d    = 1'b1;
         ram_addr_d  = pix_addr(wr_x, wr_y);
         ram_wdata_d = wr_color;
      end

      // a host write in the same cycle still goes out; the fill starts next slot
      if (state_q == IDLE && clear_start) begin
         state_d   = CLEAR;
         clr_col_d = clear_color;
         clr_cnt_d = '0;
      end
   end

   // state, RAM port and 3-stage VGA alignment pipelines
   always_ff @(posedge clk_25) begin
      if (reset) begin
         state_q      <= IDLE;
         clr_cnt_q    <= '0;
         clr_col_q    <= '0;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         clear_done_q <= 1'b0;
         wr_drop_q    <= 1'b0;
         rvld_q       <= 1'b0;
         hold_q       <= '0;
         de_q         <= '0;
         hs_q         <= {3{hsync_in}};
         vs_q         <= {3{vsync_in}};
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         clr_col_q    <= clr_col_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         clear_done_q <= clear_done_d;
         wr_drop_q    <= wr_drop_d;
         rvld_q       <= ram_en_q && !ram_we_q;
         if (rvld_q) hold_q <= ram_rdata;
         de_q         <= {de_q[1:0], in_display_area};
         hs_q         <= {hs_q[1:0], hsync_in};
         vs_q         <= {vs_q[1:0], vsync_in};
      end
   end

   assign ram_en     = ram_en_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign clear_done = clear_done_q;
   assign clear_busy = (state_q == CLEAR);
   assign wr_drop    = wr_drop_q;
   assign pixel      = de_q[2] ? hold_q : 3'b000;
   assign hsync_out  = hs_q[2];
   assign vsync_out  = vs_q[2];

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Bench for fb_scan_arbiter: behavioural RAM, a shadow framebuffer model feeding
// a 3-cycle VGA output scoreboard, a host-write vector table and hand sequences.
module tb_fb_scan_arbiter;

   logic        clk_25 = 1'b0;
   logic        reset;
   logic [9:0]  counter_x, counter_y;
   logic        in_display_area, hsync_in, vsync_in;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_x;
   logic [6:0]  wr_y;
   logic [2:0]  wr_color;
   logic        wr_drop;
   logic        clear_start;
   logic [2:0]  clear_color;
   logic        clear_busy, clear_done;
   logic        ram_en, ram_we;
   logic [14:0] ram_addr;
   logic [2:0]  ram_wdata;
   logic [2:0]  ram_rdata;
   logic [2:0]  pixel;
   logic        hsync_out, vsync_out;

   always #5 clk_25 = ~clk_25;

   fb_scan_arbiter dut (
      .clk_25(clk_25), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
      .in_display_area(in_display_area), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
      .wr_color(wr_color), .wr_drop(wr_drop), .clear_start(clear_start),
      .clear_color(clear_color), .clear_busy(clear_busy), .clear_done(clear_done),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .pixel(pixel), .hsync_out(hsync_out), .vsync_out(vsync_out)
   );

   logic [2:0] mem    [0:32767];
   logic [2:0] shadow [0:32767];

   // single-port synchronous-read RAM
   always @(posedge clk_25) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   int nchk = 0;
   int nerr = 0;
   int n_done = 0;
   int n_drop = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [14:0] fa(input int x, input int y);
      return 15'(y * 160 + x);
   endfunction

   // output scoreboard: {pixel, hsync, vsync} expected 3 cycles after the inputs
   logic [4:0] sbq[$];
   logic [2:0] last_rd = 3'b000;
   logic [2:0] cur_rd;

   always_comb begin
      cur_rd = last_rd;
      if (in_display_area && counter_x[1:0] == 2'b00)
         cur_rd = shadow[fa(int'(counter_x[9:2]), int'(counter_y[8:2]))];
   end

   always @(posedge clk_25) begin
      if (reset) begin
         sbq.delete();
         last_rd <= 3'b000;
         repeat (3) sbq.push_back({3'b000, hsync_in, vsync_in});
      end else begin
         last_rd <= cur_rd;
         sbq.push_back({in_display_area ? cur_rd : 3'b000, hsync_in, vsync_in});
      end
   end

   always @(negedge clk_25) begin
      if (sbq.size() >= 3) begin
         chk("sb_pixel", pixel, sbq[0][4:2]);
         chk("sb_hsync", hsync_out, sbq[0][1]);
         chk("sb_vsync", vsync_out, sbq[0][0]);
         void'(sbq.pop_front());
      end
      if (clear_done) n_done <= n_done + 1;
      if (wr_drop)    n_drop <= n_drop + 1;
   end

   task automatic tick();
      @(posedge clk_25);
      #1;
   endtask

   typedef struct {
      int x; int y; int col; bit de; int cx; bit rdy0; bit drop; int addr;
   } vec_t;
   vec_t tbl[8];

   initial begin
      int exp_addr, c, last_addr;
      bit done;

      for (int i = 0; i < 32768; i++) begin mem[i] = 3'b000; shadow[i] = 3'b000; end
      reset = 1'b1; counter_x = '0; counter_y = '0; in_display_area = 1'b0;
      hsync_in = 1'b1; vsync_in = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0;
      wr_color = '0; clear_start = 1'b0; clear_color = '0;
      repeat (3) tick();
      reset = 1'b0;

      // fill abandoned by a mid-frame reset
      clear_color = 3'b111; clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("fill_busy", clear_busy, 1);
      for (int i = 0; i < 40; i++) begin
         in_display_area = 1'b1; counter_y = 10'd200; counter_x = 10'(256 + i);
         tick();
      end
      chk("fill_busy_mid", clear_busy, 1);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         counter_x = 10'(296 + i);
         tick();
         chk("rst_pixel", pixel, 0);
         chk("rst_ram_en", ram_en, 0);
         chk("rst_busy", clear_busy, 0);
         chk("rst_done", clear_done, 0);
         chk("rst_wr_ready", wr_ready, 0);
      end
      reset = 1'b0; counter_x = 10'h140; #1;
      chk("post_rst_rd_slot_ready", wr_ready, 0);
      tick();
      counter_x = 10'h141; #1;
      chk("post_rst_ready", wr_ready, 1);
      chk("post_rst_busy", clear_busy, 0);
      tick();

      // full clear to 010 while scan-out keeps reading rows 0..3
      in_display_area = 1'b0; counter_x = '0; counter_y = '0;
      clear_color = 3'b010; clear_start = 1'b1;
      for (int i = 0; i < 19200; i++) shadow[i] = 3'b010;
      tick();
      clear_start = 1'b0; clear_color = 3'b101;
      chk("clr_busy", clear_busy, 1);
      exp_addr = 0; c = 0; done = 1'b0;
      while (!done && c < 30000) begin
         in_display_area = (c >= 300);
         counter_x = 10'(c % 640);
         counter_y = 10'((c / 640) % 4);
         hsync_in  = !((c % 640) >= 600 && (c % 640) < 620);
         wr_valid  = 1'b0;
         tick();
         if (ram_en && ram_we) begin
            chk("clr_addr", ram_addr, 32'(exp_addr));
            chk("clr_data", ram_wdata, 3'b010);
            exp_addr++;
         end
         if (clear_busy) chk("clr_wr_ready", wr_ready, 0);
         if (clear_done) begin
            done = 1'b1;
            chk("clr_done_addr", ram_addr, 19199);
            chk("clr_done_idle", clear_busy, 0);
         end
         c++;
      end
      chk("clr_done_seen", done, 1);
      chk("clr_write_count", exp_addr, 19200);
      hsync_in = 1'b1;
      tick();
      chk("clr_done_single", clear_done, 0);

      // host write vectors
      tbl[0] = '{10, 20, 5, 1'b0, 0, 1'b1, 1'b0, 3210};
      tbl[1] = '{159, 119, 6, 1'b0, 0, 1'b1, 1'b0, 19199};
      tbl[2] = '{160, 5, 7, 1'b0, 0, 1'b1, 1'b1, 0};
      tbl[3] = '{3, 120, 2, 1'b0, 0, 1'b1, 1'b1, 0};
      tbl[4] = '{255, 127, 1, 1'b0, 0, 1'b1, 1'b1, 0};
      tbl[5] = '{0, 0, 1, 1'b0, 0, 1'b1, 1'b0, 0};
      tbl[6] = '{40, 60, 3, 1'b1, 256, 1'b0, 1'b0, 9640};
      tbl[7] = '{1, 1, 4, 1'b1, 258, 1'b1, 1'b0, 161};
      last_addr = 0;
      for (int i = 0; i < 8; i++) begin
         counter_y = 10'd200; counter_x = 10'(tbl[i].cx); in_display_area = tbl[i].de;
         wr_x = 8'(tbl[i].x); wr_y = 7'(tbl[i].y); wr_color = 3'(tbl[i].col);
         wr_valid = 1'b1; #1;
         chk("wr_ready_first", wr_ready, tbl[i].rdy0);
         if (!tbl[i].rdy0) begin
            tick();
            chk("scan_read_kept", ram_en && !ram_we, 1);
            counter_x = 10'(tbl[i].cx + 1); #1;
            chk("wr_ready_retry", wr_ready, 1);
         end
         if (!tbl[i].drop) shadow[tbl[i].addr] = 3'(tbl[i].col);
         tick();
         wr_valid = 1'b0;
         chk("wr_en", ram_en, !tbl[i].drop);
         chk("wr_we", ram_we, !tbl[i].drop);
         chk("wr_drop", wr_drop, tbl[i].drop);
         if (!tbl[i].drop) begin
            chk("wr_addr", ram_addr, 32'(tbl[i].addr));
            chk("wr_data", ram_wdata, 32'(tbl[i].col));
            last_addr = tbl[i].addr;
         end else begin
            chk("drop_addr_hold", ram_addr, 32'(last_addr));
         end
         counter_x = 10'(tbl[i].cx + 3);
         tick();
         chk("wr_drop_pulse", wr_drop, 0);
      end

      // hand sequence: pixel 101 at (40..43, 80) and hsync falling edge latency
      in_display_area = 1'b0; hsync_in = 1'b1; counter_y = 10'd80; counter_x = 10'd36;
      repeat (3) tick();
      for (int k = 0; k < 7; k++) begin
         counter_x = 10'(40 + k);
         in_display_area = (k < 4);
         hsync_in = (k < 4);
         tick();
         if (k >= 2) chk("hand_pixel", pixel, (k - 2 <= 3) ? 3'b101 : 3'b000);
         if (k >= 4) chk("hand_hsync", hsync_out, (k == 6) ? 1'b0 : 1'b1);
      end
      hsync_in = 1'b1;

      // sweep around the written pixel
      for (int y = 76; y < 88; y++) begin
         for (int x = 28; x < 60; x++) begin
            in_display_area = 1'b1; counter_x = 10'(x); counter_y = 10'(y);
            tick();
         end
         for (int b = 0; b < 8; b++) begin
            in_display_area = 1'b0; counter_x = 10'(640 + b);
            hsync_in = !(b >= 2 && b < 6);
            vsync_in = (y != 80);
            tick();
         end
      end
      hsync_in = 1'b1; vsync_in = 1'b1;

      // clear_start together with a host transfer: write first, fill next slot
      in_display_area = 1'b0; counter_x = '0;
      wr_x = 8'd5; wr_y = 7'd5; wr_color = 3'b011; wr_valid = 1'b1;
      clear_color = 3'b100; clear_start = 1'b1; #1;
      chk("both_ready", wr_ready, 1);
      for (int i = 0; i < 19200; i++) shadow[i] = 3'b100;
      tick();
      wr_valid = 1'b0; clear_start = 1'b0;
      chk("both_host_we", ram_we, 1);
      chk("both_host_addr", ram_addr, 805);
      chk("both_host_data", ram_wdata, 3'b011);
      chk("both_busy", clear_busy, 1);
      tick();
      chk("both_fill_we", ram_we, 1);
      chk("both_fill_addr", ram_addr, 0);
      chk("both_fill_data", ram_wdata, 3'b100);
      done = 1'b0; c = 0;
      while (!done && c < 20000) begin
         tick();
         if (clear_done) done = 1'b1;
         c++;
      end
      chk("both_done_seen", done, 1);

      repeat (4) tick();
      chk("done_pulses", n_done, 2);
      chk("drop_pulses", n_drop, 3);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
